// File: rtl/cpu_control.sv
// Multi-cycle control sequencer: fetch handshake, decode pulse, MUL/stack stalls,
// and the register-file / PC / SP strobes for the CPU core.
module cpu_control #(
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] inst_lo,
  input  logic       mem_ready,
  input  logic       resume,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       decode_en,
  output logic       rf_write_en,
  output logic       sp_push,
  output logic       sp_pop,
  output logic       halted,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_MUL_WAIT = 3'd4,
    S_MEM      = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             push_op, push_op_next;  // remembers PUSH vs POP across the MEM stall

  logic [1:0] t;
  logic [2:0] op;
  logic [5:0] f;

  assign t  = inst_lo[1:0];
  assign op = inst_lo[4:2];
  assign f  = inst_lo[7:2];

  assign state_dbg = state;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RESET;
      cnt     <= '0;
      push_op <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      push_op <= push_op_next;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    state_next   = state;
    cnt_next     = cnt;
    push_op_next = push_op;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    decode_en    = 1'b0;
    rf_write_en  = 1'b0;
    sp_push      = 1'b0;
    sp_pop       = 1'b0;
    halted       = 1'b0;

    case (state)
      S_RESET: state_next = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        decode_en  = 1'b1;
        state_next = S_EXEC;
      end

      S_EXEC: begin
        case (t)
          2'b01: begin
            case (op)
              3'b000: begin
                push_op_next = 1'b1;
                state_next   = S_MEM;
              end
              3'b001: begin
                push_op_next = 1'b0;
                state_next   = S_MEM;
              end
              3'b111: begin
                cnt_next   = CNT_W'(MUL_CYCLES - 1);
                state_next = S_MUL_WAIT;
              end
              default: state_next = S_WB;
            endcase
          end
          2'b10: state_next = S_WB;
          2'b11: begin
            // Only the four shift/transfer forms are legal; anything else retires silently.
            if (f == 6'h20 || f == 6'h21 || f == 6'h30 || f == 6'h31) state_next = S_WB;
            else state_next = S_FETCH;
          end
          default: begin
            if (f == 6'h3F) state_next = S_HALT;
            else state_next = S_FETCH;
          end
        endcase
      end

      S_MUL_WAIT: begin
        if (cnt == '0) state_next = S_WB;
        else cnt_next = cnt - 1'b1;
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = push_op;
        if (mem_ready) begin
          if (push_op) begin
            sp_push    = 1'b1;
            state_next = S_FETCH;
          end else begin
            sp_pop     = 1'b1;
            state_next = S_WB;
          end
        end
      end

      S_WB: begin
        rf_write_en = 1'b1;
        state_next  = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        if (resume) state_next = S_FETCH;
      end

      default: state_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: walks ALU, MUL, PUSH/POP, HALT, illegal and
// mid-transaction reset sequences against hand-computed per-cycle outputs.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] inst_lo;
  logic       mem_ready;
  logic       resume;
  logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, decode_en;
  logic       rf_write_en, sp_push, sp_pop, halted;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Output vector order: req we asel irl pci dec rfw spu spo hlt
  localparam logic [9:0] O_NONE   = 10'b0000000000;
  localparam logic [9:0] F_WAIT   = 10'b1000000000;
  localparam logic [9:0] F_DONE   = 10'b1001100000;
  localparam logic [9:0] O_DEC    = 10'b0000010000;
  localparam logic [9:0] O_WB     = 10'b0000001000;
  localparam logic [9:0] PUSH_W   = 10'b1110000000;
  localparam logic [9:0] PUSH_D   = 10'b1110000100;
  localparam logic [9:0] POP_W    = 10'b1010000000;
  localparam logic [9:0] POP_D    = 10'b1010000010;
  localparam logic [9:0] O_HALT   = 10'b0000000001;

  logic [9:0] outs;
  assign outs = {mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, decode_en,
                 rf_write_en, sp_push, sp_pop, halted};

  cpu_control #(.MUL_CYCLES(2), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_lo      (inst_lo),
    .mem_ready    (mem_ready),
    .resume       (resume),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .decode_en    (decode_en),
    .rf_write_en  (rf_write_en),
    .sp_push      (sp_push),
    .sp_pop       (sp_pop),
    .halted       (halted),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [9:0] o);
    #1;
    check({tag, "_state"}, {13'd0, state_dbg}, {13'd0, st});
    check({tag, "_outs"}, {6'd0, outs}, {6'd0, o});
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic [9:0] o);
    tick();
    expect_cyc(tag, st, o);
  endtask

  initial begin
    rst_n     = 1'b0;
    inst_lo   = 8'h29;
    mem_ready = 1'b0;
    resume    = 1'b0;
    expect_cyc("rst_hold", 3'd0, O_NONE);
    tick();
    tick();
    rst_n = 1'b1;
    expect_cyc("rst_rel", 3'd0, O_NONE);
    step("rst_fetch", 3'd1, F_WAIT);

    // Fetch with memory delayed three cycles, then ADD 0x29
    step("dly_f2", 3'd1, F_WAIT);
    step("dly_f3", 3'd1, F_WAIT);
    tick();
    mem_ready = 1'b1;
    expect_cyc("dly_f4", 3'd1, F_DONE);
    step("add_dec", 3'd2, O_DEC);
    step("add_exec", 3'd3, O_NONE);
    step("add_wb", 3'd6, O_WB);
    step("add_refetch", 3'd1, F_DONE);

    // MUL 0x1D: two MUL_WAIT cycles, WB on cycle 6
    inst_lo = 8'h1D;
    step("mul_dec", 3'd2, O_DEC);
    step("mul_exec", 3'd3, O_NONE);
    step("mul_w1", 3'd4, O_NONE);
    step("mul_w2", 3'd4, O_NONE);
    step("mul_wb", 3'd6, O_WB);
    step("mul_refetch", 3'd1, F_DONE);

    // PUSH 0x01 with a two-cycle memory stall
    inst_lo = 8'h01;
    step("push_dec", 3'd2, O_DEC);
    step("push_exec", 3'd3, O_NONE);
    mem_ready = 1'b0;
    step("push_mem1", 3'd5, PUSH_W);
    step("push_mem2", 3'd5, PUSH_W);
    tick();
    mem_ready = 1'b1;
    expect_cyc("push_done", 3'd5, PUSH_D);
    step("push_refetch", 3'd1, F_DONE);

    // POP 0x05 zero-wait
    inst_lo = 8'h05;
    step("pop_dec", 3'd2, O_DEC);
    step("pop_exec", 3'd3, O_NONE);
    step("pop_done", 3'd5, POP_D);
    step("pop_wb", 3'd6, O_WB);
    step("pop_refetch", 3'd1, F_DONE);

    // HALT 0xFC, parked for 10 cycles, then resume
    inst_lo = 8'hFC;
    step("halt_dec", 3'd2, O_DEC);
    resume = 1'b1;  // ignored outside HALT
    step("halt_exec", 3'd3, O_NONE);
    resume = 1'b0;
    for (int i = 0; i < 10; i++) step("halt_park", 3'd7, O_HALT);
    resume    = 1'b1;
    mem_ready = 1'b0;
    step("halt_resume", 3'd1, F_WAIT);
    resume = 1'b0;

    // Illegal 0xFF retires straight to FETCH with no write
    inst_lo   = 8'hFF;
    mem_ready = 1'b1;
    expect_cyc("ill_fetch", 3'd1, F_DONE);
    step("ill_dec", 3'd2, O_DEC);
    step("ill_exec", 3'd3, O_NONE);
    step("ill_refetch", 3'd1, F_DONE);

    // Asynchronous reset while a PUSH is stalled in MEM
    inst_lo = 8'h01;
    step("rpush_dec", 3'd2, O_DEC);
    step("rpush_exec", 3'd3, O_NONE);
    mem_ready = 1'b0;
    step("rpush_mem", 3'd5, PUSH_W);
    rst_n = 1'b0;
    expect_cyc("rst_async", 3'd0, O_NONE);
    tick();
    rst_n = 1'b1;
    expect_cyc("rst2_rel", 3'd0, O_NONE);
    step("rst2_fetch", 3'd1, F_WAIT);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Multi-cycle sequencer for the CPU core.
- Drives instruction fetch through a memory request/ready handshake, pulses the decoder's decode_en, and stalls for multi-cycle ALU multiply and stack memory operations.
- Issues register-file write, PC-increment and stack-pointer strobes.
- Sits between the instruction register/decode unit and the memory, register-file, PC and SP blocks.

Parameters:
MUL_CYCLES, 2, extra EXEC cycles spent in MUL_WAIT for ALU_MUL (legal range 1..15)
CNT_W, 4, width of the internal stall counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
inst_lo  input  8  bits [7:0] of the instruction register; stable from the cycle after ir_load
mem_ready  input  1  memory completion; sampled only while mem_req=1
resume  input  1  leaves HALT when sampled high
mem_req  output  1  memory access request
mem_we  output  1  1=write (PUSH), 0=read; valid only while mem_req=1
mem_addr_sel  output  1  0=PC, 1=SP
ir_load  output  1  load instruction register from memory read data
pc_inc  output  1  PC += 1
decode_en  output  1  to decode unit: latch decoded fields
rf_write_en  output  1  register-file write strobe
sp_push  output  1  SP -= 1 after PUSH write completes
sp_pop  output  1  SP += 1 after POP read completes
halted  output  1  high while in HALT
state_dbg  output  3  current state encoding, for debug

Behaviour:
- States, 3-bit encoding: RESET=0, FETCH=1, DECODE=2, EXEC=3, MUL_WAIT=4, MEM=5, WB=6, HALT=7.
- rst_n low asynchronously forces RESET, clears the stall counter and forces every output to 0. This applies mid-transaction too; a pending mem_req is dropped.
- RESET to FETCH is unconditional, one cycle after rst_n deasserts. Outputs stay 0 in RESET.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0 every cycle until mem_ready=1.
  - In the cycle where mem_req and mem_ready are both 1, ir_load=1 and pc_inc=1 for that cycle only (Mealy), and the next state is DECODE.
  - The zero-wait fetch path is a single cycle.
- DECODE: decode_en=1 for exactly one cycle, then EXEC.
- EXEC dispatches on t=inst_lo[1:0], op=inst_lo[4:2], f=inst_lo[7:2]:
  - t=01, op=000 (PUSH): go to MEM as a write.
  - t=01, op=001 (POP): go to MEM as a read.
  - t=01, op=111 (MUL): load the counter with MUL_CYCLES-1 and go to MUL_WAIT.
  - t=01, other ops: go to WB.
  - t=10: go to WB.
  - t=11 with f in {100000 (0TOX), 100001 (XTO0), 110000 (SL), 110001 (SR)}: go to WB.
  - t=11, any other f: illegal; go to FETCH with no write.
  - t=00, f=111111 (HALT): go to HALT.
  - t=00, any other f: NOP; go to FETCH.
  - EXEC asserts no strobes.
- MUL_WAIT: the counter decrements each cycle. When it reaches 0, go to WB, so MUL_WAIT lasts exactly MUL_CYCLES cycles.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for PUSH and 0 for POP. All three are held stable until mem_ready.
  - On completion, PUSH pulses sp_push and goes to FETCH.
  - On completion, POP pulses sp_pop and goes to WB.
- WB: rf_write_en=1 for one cycle, then FETCH.
- HALT:
  - halted=1 and all other strobes are 0.
  - When resume=1 is sampled, go to FETCH; halted is low in that FETCH cycle.
  - resume is ignored in every other state.
- Handshake rules:
  - mem_req never drops before completion (except on reset).
  - mem_ready while mem_req=0 has no effect.
  - Back-to-back requests are allowed: MEM completion to FETCH reasserts mem_req on the next cycle.
- Outputs other than ir_load, pc_inc, sp_push and sp_pop are Moore, decoded from the state.
- At most one of rf_write_en, sp_push, sp_pop, ir_load is high in any cycle.
- Cycle counts with zero-wait memory, measured from the cycle FETCH is entered to the WB cycle inclusive:
  - ALU / immediate: 4 cycles.
  - MUL: 4+MUL_CYCLES cycles.
  - POP: 5 cycles.
  - PUSH: 4 cycles, ending with its MEM cycle; there is no WB.

Test Plan:
- Reset: rst_n=0 with state in MEM and mem_req=1 → all outputs 0 immediately, with no clock edge needed. After release: state_dbg=0, then 1, with mem_req=1 and mem_addr_sel=0.
- ADD, inst_lo=0x29, zero-wait memory → FETCH(ir_load, pc_inc) → DECODE(decode_en) → EXEC → WB(rf_write_en), one pulse each; mem_req reasserted on the 5th cycle.
- Fetch with mem_ready delayed 3 cycles → mem_req high for 4 cycles, mem_we=0 throughout, and ir_load/pc_inc high only in the 4th cycle.
- MUL, inst_lo=0x1D, MUL_CYCLES=2 → MUL_WAIT held exactly 2 cycles; rf_write_en on cycle 6.
- PUSH 0x01 then POP 0x05 → PUSH: mem_we=1, mem_addr_sel=1, sp_push on completion, no rf_write_en. POP: mem_we=0, sp_pop in the completion cycle, rf_write_en on the next cycle.
- HALT inst_lo=0xFC → halted=1 and resume at 0 for 10 cycles keeps it there. resume=1 → FETCH on the next cycle. Illegal 0xFF (t=11, f=111111) returns to FETCH with no rf_write_en.
